// File: rtl/kamus_lsu.sv
// Load/store unit: one memory op at a time over an L1D req/gnt/rvalid handshake,
// with alignment checking, a bus timeout, and sign/zero-extended load data.
module kamus_lsu #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            busy_o,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            l1d_req_o,
    output logic            l1d_we_o,
    output logic [XLEN-1:0] l1d_addr_o,
    output logic [3:0]      l1d_be_o,
    output logic [XLEN-1:0] l1d_wdata_o,
    input  logic            l1d_gnt_i,
    input  logic            l1d_rvalid_i,
    input  logic [XLEN-1:0] l1d_rdata_i
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      addr_lo_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic            misaligned;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            timed_out;

    assign busy_o    = (state != IDLE);
    assign timed_out = (cnt == CW'(TIMEOUT_CYC - 1));
    assign shifted   = l1d_rdata_i >> {addr_lo_q, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be_next    = 4'b0001 << req_addr_i[1:0];
                wdata_next = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr_i[0];
                be_next    = 4'b0011 << req_addr_i[1:0];
                wdata_next = {2{req_wdata_i[15:0]}};
            end
            2'b10:   misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        load_data = shifted;
        case (size_q)
            2'b00: load_data = uns_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                     : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_data = uns_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                     : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            l1d_req_o   <= 1'b0;
            l1d_we_o    <= 1'b0;
            l1d_addr_o  <= '0;
            l1d_be_o    <= '0;
            l1d_wdata_o <= '0;
        end else begin
            // Response outputs are single-cycle; they are only raised on entry to RESP.
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_lo_q <= req_addr_i[1:0];
                        size_q    <= req_size_i;
                        uns_q     <= req_unsigned_i;
                        if (misaligned) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            misalign_o  <= 1'b1;
                        end else begin
                            state       <= REQ;
                            cnt         <= '0;
                            l1d_req_o   <= 1'b1;
                            l1d_we_o    <= req_we_i;
                            l1d_addr_o  <= {req_addr_i[XLEN-1:2], 2'b00};
                            l1d_be_o    <= be_next;
                            l1d_wdata_o <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (l1d_gnt_i || timed_out) begin
                        l1d_req_o   <= 1'b0;
                        l1d_we_o    <= 1'b0;
                        l1d_addr_o  <= '0;
                        l1d_be_o    <= '0;
                        l1d_wdata_o <= '0;
                    end
                    if (l1d_gnt_i) begin
                        if (l1d_we_o) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end else if (timed_out) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        bus_err_o   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (l1d_rvalid_i) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_data;
                    end else if (timed_out) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        bus_err_o   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kamus_lsu.sv
// Directed bench for kamus_lsu; built with a short bus timeout so timeout
// and gnt-vs-timeout boundaries are reachable in a few cycles.
module tb_kamus_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rsp_valid, misalign, bus_err;
    logic [31:0] rsp_rdata;
    logic        l1d_req, l1d_we, l1d_gnt, l1d_rvalid;
    logic [31:0] l1d_addr, l1d_wdata, l1d_rdata;
    logic [3:0]  l1d_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kamus_lsu #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .busy_o(busy), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .misalign_o(misalign), .bus_err_o(bus_err),
        .l1d_req_o(l1d_req), .l1d_we_o(l1d_we), .l1d_addr_o(l1d_addr),
        .l1d_be_o(l1d_be), .l1d_wdata_o(l1d_wdata),
        .l1d_gnt_i(l1d_gnt), .l1d_rvalid_i(l1d_rvalid), .l1d_rdata_i(l1d_rdata)
    );

    // Presents one request for exactly one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; l1d_gnt = 1'b0; l1d_rvalid = 1'b0; l1d_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (l1d_req !== 1'b0) begin bad++; $display("FAIL reset_l1d_req got=%0h exp=0", l1d_req); end
        total++; if ({rsp_rdata, l1d_addr, l1d_be} !== 68'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", {rsp_rdata, l1d_addr, l1d_be}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        logic [31:0] aaddr, awd;
    } st_vec_t;

    task automatic test_store();
        st_vec_t v [4];
        v = '{'{2'b00, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB},
              '{2'b01, 32'h0000_1002, 32'hFFFF_1234, 4'b1100, 32'h0000_1000, 32'h1234_1234},
              '{2'b10, 32'h0000_1008, 32'h1234_5678, 4'b1111, 32'h0000_1008, 32'h1234_5678},
              '{2'b00, 32'h0000_1000, 32'h0000_11CD, 4'b0001, 32'h0000_1000, 32'hCDCD_CDCD}};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, v[i].sz, 1'b0, v[i].addr, v[i].wd);
            total++; if (l1d_req !== 1'b1 || l1d_we !== 1'b1) begin bad++; $display("FAIL st%0d_req got=%b%b exp=11", i, l1d_req, l1d_we); end
            total++; if (l1d_be !== v[i].be) begin bad++; $display("FAIL st%0d_be got=%b exp=%b", i, l1d_be, v[i].be); end
            total++; if (l1d_addr !== v[i].aaddr) begin bad++; $display("FAIL st%0d_addr got=%h exp=%h", i, l1d_addr, v[i].aaddr); end
            total++; if (l1d_wdata !== v[i].awd) begin bad++; $display("FAIL st%0d_wdata got=%h exp=%h", i, l1d_wdata, v[i].awd); end
            total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL st%0d_c1 busy/rsp got=%b%b exp=10", i, busy, rsp_valid); end
            l1d_gnt = 1'b1;
            @(negedge clk);
            l1d_gnt = 1'b0;
            total++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL st%0d_rsp rsp/busy got=%b%b exp=11", i, rsp_valid, busy); end
            total++; if (misalign !== 1'b0 || bus_err !== 1'b0 || rsp_rdata !== 32'h0 || l1d_req !== 1'b0) begin
                bad++; $display("FAIL st%0d_flags got=%b%b %h %b exp=00 0 0", i, misalign, bus_err, rsp_rdata, l1d_req); end
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL st%0d_done rsp/busy got=%b%b exp=00", i, rsp_valid, busy); end
        end
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, rd;
        logic [3:0]  be;
        logic [31:0] aaddr, exp;
    } ld_vec_t;

    task automatic test_load();
        ld_vec_t v [6];
        v = '{'{2'b00, 1'b0, 32'h0000_2001, 32'h0000_8000, 4'b0010, 32'h0000_2000, 32'hFFFF_FF80},
              '{2'b00, 1'b1, 32'h0000_2001, 32'h0000_8000, 4'b0010, 32'h0000_2000, 32'h0000_0080},
              '{2'b01, 1'b0, 32'h0000_2002, 32'h8001_0000, 4'b1100, 32'h0000_2000, 32'hFFFF_8001},
              '{2'b01, 1'b1, 32'h0000_2002, 32'h8001_0000, 4'b1100, 32'h0000_2000, 32'h0000_8001},
              '{2'b10, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_2004, 32'hDEAD_BEEF},
              '{2'b00, 1'b0, 32'h0000_2003, 32'h7F00_0000, 4'b1000, 32'h0000_2000, 32'h0000_007F}};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, v[i].sz, v[i].uns, v[i].addr, 32'h0);
            total++; if (l1d_req !== 1'b1 || l1d_we !== 1'b0) begin bad++; $display("FAIL ld%0d_req got=%b%b exp=10", i, l1d_req, l1d_we); end
            total++; if (l1d_be !== v[i].be || l1d_addr !== v[i].aaddr) begin bad++; $display("FAIL ld%0d_be_addr got=%b %h exp=%b %h", i, l1d_be, l1d_addr, v[i].be, v[i].aaddr); end
            l1d_gnt = 1'b1;
            @(negedge clk);
            l1d_gnt = 1'b0; l1d_rvalid = 1'b1; l1d_rdata = v[i].rd;
            total++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || l1d_req !== 1'b0) begin bad++; $display("FAIL ld%0d_wait got=%b%b%b exp=100", i, busy, rsp_valid, l1d_req); end
            @(negedge clk);
            l1d_rvalid = 1'b0; l1d_rdata = 32'h0;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ld%0d_rsp_valid got=%b exp=1", i, rsp_valid); end
            total++; if (rsp_rdata !== v[i].exp) begin bad++; $display("FAIL ld%0d_rdata got=%h exp=%h", i, rsp_rdata, v[i].exp); end
            total++; if (misalign !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL ld%0d_flags got=%b%b exp=00", i, misalign, bus_err); end
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL ld%0d_done got=%b%b %h exp=00 0", i, rsp_valid, busy, rsp_rdata); end
        end
    endtask

    task automatic test_misalign();
        logic [1:0]  sz [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
        logic [31:0] ad [5] = '{32'h2001, 32'h2002, 32'h2001, 32'h2000, 32'h1003};
        logic        we [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            issue(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
            total++; if (rsp_valid !== 1'b1 || misalign !== 1'b1) begin bad++; $display("FAIL mis%0d_rsp got=%b%b exp=11", i, rsp_valid, misalign); end
            total++; if (l1d_req !== 1'b0 || bus_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL mis%0d_side got=%b%b %h exp=00 0", i, l1d_req, bus_err, rsp_rdata); end
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0 || misalign !== 1'b0 || busy !== 1'b0 || l1d_req !== 1'b0) begin
                bad++; $display("FAIL mis%0d_done got=%b%b%b%b exp=0000", i, rsp_valid, misalign, busy, l1d_req); end
        end
    endtask

    // gnt arrives on the last REQ cycle before timeout; gnt must win.
    task automatic test_gnt_delay();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_3004, 32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            total++; if (l1d_req !== 1'b1 || l1d_addr !== 32'h0000_3004 || l1d_be !== 4'b1111 || l1d_wdata !== 32'h1234_5678 || rsp_valid !== 1'b0) begin
                bad++; $display("FAIL gdly_c%0d got=%b %h %b %h %b exp=1 3004 1111 12345678 0", c, l1d_req, l1d_addr, l1d_be, l1d_wdata, rsp_valid); end
            if (c == 3) l1d_gnt = 1'b1;
            @(negedge clk);
        end
        l1d_gnt = 1'b0;
        total++; if (rsp_valid !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL gdly_rsp got=%b%b exp=10", rsp_valid, bus_err); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gdly_idle got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h0000_0001);
        for (int c = 0; c < 4; c++) begin
            total++; if (l1d_req !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL to_req_c%0d got=%b%b exp=10", c, l1d_req, rsp_valid); end
            @(negedge clk);
        end
        total++; if (rsp_valid !== 1'b1 || bus_err !== 1'b1 || rsp_rdata !== 32'h0 || l1d_req !== 1'b0) begin
            bad++; $display("FAIL to_req_err got=%b%b %h %b exp=11 0 0", rsp_valid, bus_err, rsp_rdata, l1d_req); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || bus_err !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL to_req_idle got=%b%b%b exp=000", busy, bus_err, rsp_valid); end
        // Load granted but rvalid never arrives: times out in WAIT.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        l1d_gnt = 1'b1;
        @(negedge clk);
        l1d_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL to_wait_c%0d got=%b%b exp=10", c, busy, rsp_valid); end
            @(negedge clk);
        end
        total++; if (rsp_valid !== 1'b1 || bus_err !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_wait_err got=%b%b %h exp=11 0", rsp_valid, bus_err, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        // Stray handshake inputs while idle.
        l1d_gnt = 1'b1; l1d_rvalid = 1'b1; l1d_rdata = 32'h5555_5555;
        @(negedge clk); @(negedge clk);
        l1d_gnt = 1'b0; l1d_rvalid = 1'b0; l1d_rdata = 32'h0;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || l1d_req !== 1'b0) begin bad++; $display("FAIL stray_idle got=%b%b%b exp=000", rsp_valid, busy, l1d_req); end
        // New request while busy must not disturb the op in flight.
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h0000_0042);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_5554;
        @(negedge clk);
        total++; if (l1d_addr !== 32'h0000_1000 || l1d_be !== 4'b0010 || l1d_we !== 1'b1) begin
            bad++; $display("FAIL busy_hold got=%h %b %b exp=1000 0010 1", l1d_addr, l1d_be, l1d_we); end
        l1d_gnt = 1'b1;
        @(negedge clk);
        l1d_gnt = 1'b0; req_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL busy_rsp got=%b exp=1", rsp_valid); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || l1d_req !== 1'b0) begin bad++; $display("FAIL busy_not_queued got=%b%b exp=00", busy, l1d_req); end
        req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0;
    endtask

    task automatic test_reset_mid_op();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        l1d_gnt = 1'b1;
        @(negedge clk);
        l1d_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || l1d_req !== 1'b0 || l1d_addr !== 32'h0) begin
            bad++; $display("FAIL rst_mid_outs got=%b%b%b %h exp=000 0", busy, rsp_valid, l1d_req, l1d_addr); end
        @(negedge clk);
        rst_n = 1'b1; l1d_rvalid = 1'b1; l1d_rdata = 32'h1111_2222;
        @(negedge clk);
        l1d_rvalid = 1'b0; l1d_rdata = 32'h0;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_norsp got=%b%b %h exp=00 0", rsp_valid, busy, rsp_rdata); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_norsp2 got=%b exp=0", rsp_valid); end
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4008, 32'h0);
        total++; if (l1d_req !== 1'b1 || l1d_addr !== 32'h0000_4008) begin bad++; $display("FAIL rst_next_req got=%b %h exp=1 4008", l1d_req, l1d_addr); end
        l1d_gnt = 1'b1;
        @(negedge clk);
        l1d_gnt = 1'b0; l1d_rvalid = 1'b1; l1d_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        l1d_rvalid = 1'b0; l1d_rdata = 32'h0;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_BABE) begin bad++; $display("FAIL rst_next_rsp got=%b %h exp=1 cafebabe", rsp_valid, rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_gnt_delay();
        test_timeout();
        test_ignore();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
